// File: rtl/mem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, waits a fixed
// latency, performs the access, then holds the response until the initiator takes it.
module mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    error_q, error_d;
  logic                    write_q, write_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;

  logic [31:0]             mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    addr_err;
  logic                    access;
  logic                    mem_we;

  assign idx      = addr_q[DEPTH_LOG2+1:2];
  // Any set bit above the array's word index means the word is out of range.
  assign addr_err = (addr_q[1:0] != 2'b00) ||
                    ((addr_q[31:2] >> DEPTH_LOG2) != 30'd0);
  assign access   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign mem_we   = access && write_q && !addr_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    error_d = error_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_RESP;
          valid_d = 1'b1;
          error_d = addr_err;
          rdata_d = (addr_err || write_q) ? 32'd0 : mem[idx];
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          rdata_d = 32'd0;
          error_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        rdata_d = 32'd0;
        error_d = 1'b0;
      end
    endcase

    // Registered so req_ready stays low through reset and rises one edge after release.
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Request payload is only meaningful while WAIT, so it carries no reset.
  always_ff @(posedge clk) begin
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

endmodule
